// File: rtl/soc_dbg_ring_meander.sv
// Debug-ring interconnect for an X x Y mesh: the debug interface and every
// tile are chained in meander (boustrophedon) order on each ring channel,
// with a FWFT FIFO on every hop, runtime tile bypass that only switches while
// the ring is idle, and saturating per-ring delivered-flit counters.

// Per-hop first-word-fall-through FIFO; DEPTH=0 degenerates to a wire.
module soc_dbg_ring_meander_fifo #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              empty
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = clk ^ rst;
    assign out_flit  = in_flit;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign empty     = 1'b1;
  end else begin : g_buf
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;

    // Ready is simply "not full": no push is accepted into a full FIFO even
    // if the head is leaving in the same cycle.
    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign empty     = (cnt == '0);
    assign out_flit  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy and pointers; reset empties the FIFO, dropping in-flight flits.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // Flit storage carries no reset; validity lives in the occupancy count.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_flit;
    end
  end

endmodule

module soc_dbg_ring_meander #(
  parameter int X         = 2,
  parameter int Y         = 2,
  parameter int RINGS     = 2,
  parameter int FLIT_W    = 18,
  parameter int HOP_DEPTH = 1,
  parameter logic [X*Y-1:0] BYPASS_RESET = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RINGS*FLIT_W-1:0]   if_out_flit,
  input  logic [RINGS-1:0]          if_out_valid,
  output logic [RINGS-1:0]          if_out_ready,
  output logic [RINGS*FLIT_W-1:0]   if_in_flit,
  output logic [RINGS-1:0]          if_in_valid,
  input  logic [RINGS-1:0]          if_in_ready,
  output logic [X*Y*RINGS*FLIT_W-1:0] tile_in_flit,
  output logic [X*Y*RINGS-1:0]      tile_in_valid,
  input  logic [X*Y*RINGS-1:0]      tile_in_ready,
  input  logic [X*Y*RINGS*FLIT_W-1:0] tile_out_flit,
  input  logic [X*Y*RINGS-1:0]      tile_out_valid,
  output logic [X*Y*RINGS-1:0]      tile_out_ready,
  input  logic [X*Y-1:0]            bypass_req,
  output logic [X*Y-1:0]            bypass_active,
  output logic                      quiescent,
  output logic [RINGS*32-1:0]       flit_count
);

  localparam int N = X * Y;

  // k-th tile visited by the ring: even rows left-to-right, odd rows reversed.
  function automatic int order_of(input int k);
    int row;
    int col;
    row = k / X;
    col = k % X;
    if ((row % 2) == 1) col = X - 1 - col;
    return row * X + col;
  endfunction

  // Hop k input side (hi_*) and output side (ho_*), per ring.
  logic [FLIT_W-1:0] hi_flit  [RINGS][N+1];
  logic              hi_valid [RINGS][N+1];
  logic              hi_ready [RINGS][N+1];
  logic [FLIT_W-1:0] ho_flit  [RINGS][N+1];
  logic              ho_valid [RINGS][N+1];
  logic              ho_ready [RINGS][N+1];
  logic              h_empty  [RINGS][N+1];

  for (genvar r = 0; r < RINGS; r++) begin : g_ring
    for (genvar k = 0; k <= N; k++) begin : g_hop
      soc_dbg_ring_meander_fifo #(
        .DATA_W (FLIT_W),
        .DEPTH  (HOP_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (hi_flit[r][k]),
        .in_valid  (hi_valid[r][k]),
        .in_ready  (hi_ready[r][k]),
        .out_flit  (ho_flit[r][k]),
        .out_valid (ho_valid[r][k]),
        .out_ready (ho_ready[r][k]),
        .empty     (h_empty[r][k])
      );
    end

    assign hi_flit[r][0]  = if_out_flit[r*FLIT_W +: FLIT_W];
    assign hi_valid[r][0] = if_out_valid[r];
    assign if_out_ready[r] = hi_ready[r][0];

    // Tile between hop k-1 and hop k; a bypassed tile is spliced out and
    // sees neither valid nor ready, while both hop FIFOs stay in the path.
    for (genvar k = 1; k <= N; k++) begin : g_tile
      localparam int T   = order_of(k - 1);
      localparam int IDX = T * RINGS + r;

      assign tile_in_flit[IDX*FLIT_W +: FLIT_W] = ho_flit[r][k-1];
      assign tile_in_valid[IDX]  = ho_valid[r][k-1] & ~bypass_active[T];
      assign tile_out_ready[IDX] = hi_ready[r][k] & ~bypass_active[T];
      assign ho_ready[r][k-1]    = bypass_active[T] ? hi_ready[r][k] : tile_in_ready[IDX];
      assign hi_flit[r][k]       = bypass_active[T] ? ho_flit[r][k-1]
                                                    : tile_out_flit[IDX*FLIT_W +: FLIT_W];
      assign hi_valid[r][k]      = bypass_active[T] ? ho_valid[r][k-1] : tile_out_valid[IDX];
    end

    assign if_in_flit[r*FLIT_W +: FLIT_W] = ho_flit[r][N];
    assign if_in_valid[r] = ho_valid[r][N];
    assign ho_ready[r][N] = if_in_ready[r];
  end

  // Ring is idle when nothing is buffered and nobody is offering a flit.
  always_comb begin
    quiescent = ~|if_out_valid;
    for (int r = 0; r < RINGS; r++) begin
      for (int k = 0; k <= N; k++) begin
        if (!h_empty[r][k]) quiescent = 1'b0;
      end
    end
    for (int t = 0; t < N; t++) begin
      for (int r = 0; r < RINGS; r++) begin
        if (!bypass_active[t] && tile_out_valid[t*RINGS+r]) quiescent = 1'b0;
      end
    end
  end

  // Bypass mask only follows the request while idle, so a packet is never split.
  always_ff @(posedge clk) begin
    if (rst)            bypass_active <= BYPASS_RESET;
    else if (quiescent) bypass_active <= bypass_req;
  end

  for (genvar r = 0; r < RINGS; r++) begin : g_cnt
    logic [31:0] cnt_q;

    // Saturating count of flits handed back to the debug interface.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (if_in_valid[r] && if_in_ready[r] && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end

    assign flit_count[r*32 +: 32] = cnt_q;
  end

endmodule
